seq_mult: RTL
=============

Name: seq_mult

Overview:
- Sequential unsigned shift-add multiplier; the inverse operation of the team's restoring divider.
- Accepts a multiplicand/multiplier pair over a valid/ready handshake and computes one partial-product bit per clock.
- Presents a 2*WIDTH-bit product over a valid/ready handshake.
- Sits in the same arithmetic datapath as the divider, so that a quotient can be multiplied back to check a division result.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits; legal WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- in1  input  WIDTH  multiplicand, unsigned
- in2  input  WIDTH  multiplier, unsigned
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- out  output  2*WIDTH  product in1*in2
- zero  output  1  product equals 0; qualified by out_valid

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low; it is sampled only on rising edges of clk.
- Reset values: state=IDLE, out=0, zero=0, out_valid=0, internal counter/accumulator=0. in_ready=1 on the first cycle after reset release.
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE), decoded combinationally from state only and independent of in_valid. out_valid = (state==DONE), registered.
- IDLE:
  - On an edge where in_valid&&in_ready, capture mcand<=in1, mplr<=in2, acc_hi<=0, cnt<=0, then go to RUN.
  - in1/in2 are ignored at all other times; changes after capture do not affect the result.
- RUN, one iteration per edge:
  - If mplr[0]: sum = {1'b0,acc_hi} + mcand, a WIDTH+1-bit add so the carry is kept. Otherwise sum = {1'b0,acc_hi}.
  - {acc_hi,mplr} <= {sum,mplr[WIDTH-1:1]}, i.e. the 2*WIDTH+1-bit concatenation shifted right by one.
  - cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1, perform the final iteration and move to DONE. On that same edge, load out <= {acc_hi_next, mplr_next} and zero <= (that value == 0).
- Latency: accept edge E; out_valid is high after edge E+WIDTH, i.e. WIDTH cycles. Latency is fixed and does not depend on the data; there is no early exit for zero operands.
- DONE:
  - out and zero are held stable while out_valid=1.
  - On an edge where out_ready=1, go to IDLE and clear out_valid; out retains its value.
  - If out_ready is held at 1, there is one IDLE cycle before the next accept, so back-to-back throughput is one result per WIDTH+2 cycles.
- Backpressure: out_ready low holds DONE indefinitely. in_ready stays 0, so no new operands are accepted and none are lost.
- in_valid while busy (RUN/DONE): ignored. The upstream holds in_valid until in_ready.
- out_ready while not DONE: ignored.
- Reset mid-operation: rst_n=0 on any edge in any state aborts the computation. All outputs go to their reset values on that edge, and the partial result is discarded.
- Arithmetic: the product is exact and cannot overflow 2*WIDTH bits. The maximum is (2^WIDTH-1)^2 = 0xFE01 for WIDTH=8.

Test Plan:
- Reset: rst_n low 2 cycles, mid-stream and at start -> in_ready=1, out_valid=0, out=0, zero=0 on the first cycle after release.
- Basic: in1=13, in2=11, accepted at edge E, out_ready=1 -> out_valid rises after E+8, out=143 (0x008F), zero=0; one cycle later out_valid=0 and in_ready=1.
- Extremes: 255*255 -> 0xFE01; 255*1 -> 0x00FF; 0*200 -> 0x0000 with zero=1 and full 8-cycle latency; 128*2 -> 0x0100.
- Backpressure/robustness:
  - Hold out_ready=0 for 20 cycles after out_valid -> out stays constant, in_ready=0.
  - Toggle in1/in2 and hold in_valid=1 during RUN -> result unchanged, no extra accept.
  - Release out_ready -> exactly one transfer.
- Abort: accept 200*3, assert rst_n=0 at cnt=4 for 1 cycle -> out_valid never rises for that op; a subsequent 7*9 -> 63 after 8 cycles.
- Random: 1000 random pairs with randomized in_valid/out_ready gaps, checked against a scoreboard of in1*in2 -> all match, order preserved, no drop or duplicate. Repeat with WIDTH=4 (15*15 -> 0xE1).

Source files
------------

// File: rtl/seq_mult.sv
// Sequential unsigned shift-add multiplier: in1*in2 -> 2*WIDTH-bit product, one multiplier bit per clock.
// Latency: WIDTH cycles from the accept edge to out_valid; no early exit for zero operands.
// Backpressure: the product is held in DONE until out_ready; in_ready stays low the whole time, so nothing is lost.
module seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out,
    output logic                 zero
);

    // cnt only has to reach WIDTH-1, so clog2(WIDTH) bits are enough (1 bit at WIDTH=2)
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [WIDTH-1:0]  mcand;       // captured multiplicand
    logic [WIDTH-1:0]  mplr;        // multiplier, shifted right; low product bits fill in from the top
    logic [WIDTH-1:0]  acc_hi;      // upper half of the running product
    logic [CW-1:0]     cnt;         // iteration index within RUN

    logic [WIDTH:0]    sum;         // one bit wider than acc_hi so the add carry survives the shift
    logic [WIDTH-1:0]  acc_hi_nxt;
    logic [WIDTH-1:0]  mplr_nxt;
    logic [2*WIDTH-1:0] prod_nxt;

    logic              accept;
    logic              last_iter;
    logic              release_out;

    // Accept only when idle; in_ready depends on state alone so it never combinationally follows in_valid
    assign in_ready    = (state == IDLE);
    assign accept      = in_valid && in_ready;
    assign last_iter   = (state == RUN) && (cnt == LAST);
    assign release_out = (state == DONE) && out_ready;

    // One shift-add step: conditionally add mcand, then shift {sum, mplr} right by one
    always_comb begin
        sum        = {1'b0, acc_hi};
        if (mplr[0]) begin
            sum = {1'b0, acc_hi} + {1'b0, mcand};
        end
        acc_hi_nxt = sum[WIDTH:1];
        mplr_nxt   = {sum[0], mplr[WIDTH-1:1]};
        prod_nxt   = {acc_hi_nxt, mplr_nxt};
    end

    // Next-state decode: IDLE -> RUN on accept, RUN -> DONE on last iteration, DONE -> IDLE on out_ready
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (release_out) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register with synchronous abort on rst_n low
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // out_valid is a registered copy of "next state is DONE" so it is glitch-free
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state_nxt == DONE);
        end
    end

    // Operand capture and iteration; a reset on any edge discards the partial product
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplr   <= '0;
            acc_hi <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand  <= in1;
                        mplr   <= in2;
                        acc_hi <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    acc_hi <= acc_hi_nxt;
                    mplr   <= mplr_nxt;
                    cnt    <= cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Result register: loaded on the final iteration, held through DONE and after hand-off
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out  <= '0;
            zero <= 1'b0;
        end else if (last_iter) begin
            out  <= prod_nxt;
            zero <= (prod_nxt == '0);
        end
    end

endmodule
